// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and helpers for the PWM soft-start / soft-reverse sequencer.
package pwm_ramp_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BRAKE = 2'd2,
        DWELL = 2'd3
    } ramp_state_t;

    // Magnitude of a sign-extended two's complement value, limited to the
    // largest positive value of a width-bit word (so -2^(width-1) maps to
    // 2^(width-1)-1).
    function automatic logic [31:0] sat_mag(input logic signed [31:0] value, input int width);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (width - 1)) - 32'd1;
        mag = value[31] ? 32'(-value) : 32'(value);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_synch_tick.sv
// Synch rising-edge detector plus StepPeriods prescaler.
// edge_o pulses on every Synch rising edge; tick_o only on every StepPeriods-th.
module pwm_ramp_sequencer_synch_tick #(
    parameter int StepPeriods = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic synch,
    output logic edge_o,
    output logic tick_o
);
    localparam int PW = (StepPeriods > 1) ? $clog2(StepPeriods) : 1;

    logic          synch_q, synch_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          presc_wrap;

    // Edge detect against the registered Synch and advance the prescaler per edge.
    always_comb begin
        synch_d    = synch;
        edge_o     = synch & ~synch_q;
        presc_wrap = (presc_q == PW'(StepPeriods - 1));
        tick_o     = edge_o & presc_wrap;
        presc_d    = presc_q;
        if (edge_o) begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        end
    end

    // Synch history and prescaler state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synch_q <= 1'b0;
            presc_q <= '0;
        end else begin
            synch_q <= synch_d;
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start / soft-reverse duty sequencer between the data generator and the
// PWM generator. Slews Data_Out toward the effective target once per qualified
// PWM period and sequences sign changes as brake -> dwell at zero -> ramp.
// Optional feature: define RAMP_ESTOP_EN to add the Estop input (immediate
// zero, then a normal dwell before ramping again).
module pwm_ramp_sequencer
    import pwm_ramp_sequencer_pkg::*;
#(
    parameter int Size         = 10,
    parameter int Step         = 8,
    parameter int StepPeriods  = 1,
    parameter int DwellPeriods = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic signed [Size-1:0] Target,
    input  logic                   Synch,
`ifdef RAMP_ESTOP_EN
    input  logic                   Estop,
`endif
    output logic signed [Size-1:0] Data_Out,
    output logic                   AtTarget,
    output logic                   Reversing,
    output logic                   Busy
);
    localparam int CW = (DwellPeriods > 0) ? $clog2(DwellPeriods + 1) : 1;
    localparam logic [Size-1:0] STEP_M = Size'(Step);

    ramp_state_t              state_q, state_d;
    logic signed [Size-1:0]   data_q, data_d;
    logic                     at_q, at_d;
    logic                     rev_q, rev_d;
    logic                     busy_q, busy_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic                     edge_w, tick_w;
    logic signed [Size-1:0]   t_eff, t_cl, new_data;
    logic [Size-1:0]          t_mag, d_mag, new_mag;
    logic [Size:0]            sum;
    logic                     t_neg, d_neg, new_neg, mismatch;

    pwm_ramp_sequencer_synch_tick #(
        .StepPeriods(StepPeriods)
    ) u_synch_tick (
        .clk    (Clock),
        .rst    (Reset),
        .synch  (Synch),
        .edge_o (edge_w),
        .tick_o (tick_w)
    );

    // Magnitude datapath: candidate next Data_Out for a qualified tick.
    always_comb begin
        t_eff    = Enable ? Target : '0;
        t_mag    = Size'(sat_mag(32'(t_eff), Size));
        t_neg    = t_eff[Size-1];
        t_cl     = t_neg ? -$signed(t_mag) : $signed(t_mag);
        d_mag    = Size'(sat_mag(32'(data_q), Size));
        d_neg    = data_q[Size-1];
        mismatch = (d_mag != '0) && (t_mag != '0) && (d_neg != t_neg);
        sum      = {1'b0, d_mag} + {1'b0, STEP_M};
        new_mag  = d_mag;
        new_neg  = d_neg;
        if (mismatch) begin
            // Braking toward zero before the direction may change.
            new_mag = (d_mag > STEP_M) ? d_mag - STEP_M : '0;
        end else if (d_mag < t_mag) begin
            // Growing; from zero the new sign is taken from the target.
            new_mag = (sum > {1'b0, t_mag}) ? t_mag : sum[Size-1:0];
            new_neg = t_neg;
        end else if (d_mag > t_mag) begin
            new_mag = ((d_mag - t_mag) > STEP_M) ? d_mag - STEP_M : t_mag;
        end
        new_data = new_neg ? -$signed(new_mag) : $signed(new_mag);
    end

    // Sequencing FSM next-state and registered status outputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef RAMP_ESTOP_EN
        if (Estop) begin
            state_d = DWELL;
            data_d  = '0;
            cnt_d   = '0;
        end else
`endif
        if (state_q == DWELL) begin
            if (DwellPeriods == 0) begin
                state_d = (t_mag != '0) ? RAMP : IDLE;
            end else if (edge_w) begin
                if ((cnt_q + CW'(1)) == CW'(DwellPeriods)) begin
                    state_d = (t_mag != '0) ? RAMP : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (tick_w) begin
            data_d = new_data;
            if (mismatch) begin
                cnt_d = '0;
                if (new_mag != '0) begin
                    state_d = BRAKE;
                end else begin
                    state_d = (DwellPeriods == 0) ? RAMP : DWELL;
                end
            end else begin
                state_d = ((new_mag == '0) && (t_mag == '0)) ? IDLE : RAMP;
            end
        end
        at_d   = (data_d == t_cl);
        rev_d  = (state_d == BRAKE) || (state_d == DWELL);
        busy_d = (state_d != IDLE);
    end

    // State, duty and status registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            at_q    <= 1'b1;
            rev_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            at_q    <= at_d;
            rev_q   <= rev_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Data_Out  = data_q;
    assign AtTarget  = at_q;
    assign Reversing = rev_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: a per-edge behavioural model checked every
// cycle, plus directed sequences with literal expected duty values.
// Build with RAMP_ESTOP_EN defined to include the Estop sequence.
module tb_pwm_ramp_sequencer;
    localparam int SIZE = 10;
    localparam int STEP = 16;
    localparam int DW   = 4;
    localparam int M_IDLE = 0, M_RAMP = 1, M_BRAKE = 2, M_DWELL = 3;

    logic clk = 1'b0, rst = 1'b0, rst3 = 1'b0;
    logic enable = 1'b1, synch = 1'b0, estop = 1'b0;
    logic signed [SIZE-1:0] target = '0;
    logic signed [SIZE-1:0] d1, d3;
    logic at1, rev1, busy1, at3, rev3, busy3;
    int n_tests = 0, n_fail = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(.Size(SIZE), .Step(STEP), .StepPeriods(1), .DwellPeriods(DW)) dut (
        .Clock(clk), .Reset(rst), .Enable(enable), .Target(target), .Synch(synch),
`ifdef RAMP_ESTOP_EN
        .Estop(estop),
`endif
        .Data_Out(d1), .AtTarget(at1), .Reversing(rev1), .Busy(busy1));

    pwm_ramp_sequencer #(.Size(SIZE), .Step(STEP), .StepPeriods(3), .DwellPeriods(DW)) dut3 (
        .Clock(clk), .Reset(rst3), .Enable(enable), .Target(target), .Synch(synch),
`ifdef RAMP_ESTOP_EN
        .Estop(estop),
`endif
        .Data_Out(d3), .AtTarget(at3), .Reversing(rev3), .Busy(busy3));

    typedef struct packed {
        int out;
        int mode;
        int dcnt;
        int presc;
        bit prev;
        bit at;
    } mdl_t;

    mdl_t m1, m3;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.out = 0; m.mode = M_IDLE; m.dcnt = 0; m.presc = 0; m.prev = 1'b0; m.at = 1'b1;
        return m;
    endfunction

    function automatic int eff_t(bit en, logic signed [SIZE-1:0] tg);
        int v;
        v = en ? int'(tg) : 0;
        if (v == -512) v = -511;
        return v;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock edge of the sequencer, stated in signed-duty terms.
    function automatic mdl_t mstep(mdl_t m, int t, bit s, bit es, int sp);
        bit edg, tick;
        int mag;
        edg    = s && !m.prev;
        m.prev = s;
        tick   = edg && (m.presc == sp - 1);
        if (edg) m.presc = (m.presc + 1) % sp;
        if (es) begin
            m.out = 0; m.mode = M_DWELL; m.dcnt = 0;
        end else if (m.mode == M_DWELL) begin
            if (edg) begin
                m.dcnt++;
                if (m.dcnt >= DW) m.mode = (t != 0) ? M_RAMP : M_IDLE;
            end
        end else if (tick) begin
            if (m.out != 0 && t != 0 && ((m.out < 0) != (t < 0))) begin
                mag = iabs(m.out) - STEP;
                if (mag < 0) mag = 0;
                m.out = (m.out < 0) ? -mag : mag;
                if (m.out == 0) begin
                    m.mode = (DW == 0) ? M_RAMP : M_DWELL;
                    m.dcnt = 0;
                end else begin
                    m.mode = M_BRAKE;
                end
            end else begin
                if (m.out < t) m.out = (m.out + STEP > t) ? t : m.out + STEP;
                else if (m.out > t) m.out = (m.out - STEP < t) ? t : m.out - STEP;
                m.mode = (m.out == 0 && t == 0) ? M_IDLE : M_RAMP;
            end
        end
        m.at = (m.out == t);
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m1 <= mdl_reset();
        else     m1 <= mstep(m1, eff_t(enable, target), synch, estop, 1);
    end

    always @(posedge clk or posedge rst3) begin
        if (rst3) m3 <= mdl_reset();
        else      m3 <= mstep(m3, eff_t(enable, target), synch, estop, 3);
    end

    task automatic cmp_dut(string nm, mdl_t m, int d, bit at, bit rev, bit busy);
        bit e_rev, e_busy;
        e_rev  = (m.mode == M_BRAKE) || (m.mode == M_DWELL);
        e_busy = (m.mode != M_IDLE);
        n_tests++;
        if (d != m.out || at != m.at || rev != e_rev || busy != e_busy) begin
            n_fail++;
            $display("FAIL %s cycle: got out=%0d at=%0b rev=%0b busy=%0b, required out=%0d at=%0b rev=%0b busy=%0b",
                     nm, d, at, rev, busy, m.out, m.at, e_rev, e_busy);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            cmp_dut("model_dut", m1, int'(d1), at1, rev1, busy1);
            cmp_dut("model_dut3", m3, int'(d3), at3, rev3, busy3);
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // One PWM period: Synch high for 2 clocks, low for 3, then sample.
    task automatic pulse();
        @(posedge clk); #1 synch = 1'b1;
        repeat (2) @(posedge clk);
        #1 synch = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp2 [7]  = '{16, 32, 48, 64, 80, 96, 100};
        int exp3 [7]  = '{84, 68, 52, 36, 20, 4, 0};
        int exp3b [3] = '{-16, -32, -40};
        int exp5 [6]  = '{0, 0, 16, 16, 16, 32};

        #1 rst = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("reset_out", int'(d1), 0);
        chk("reset_at", int'(at1), 1);
        chk("reset_rev", int'(rev1), 0);
        chk("reset_busy", int'(busy1), 0);

        // Idle with zero target
        repeat (20) pulse();
        chk("idle_out", int'(d1), 0);
        chk("idle_at", int'(at1), 1);
        chk("idle_busy", int'(busy1), 0);

        // Ramp up to +100
        target = 10'sd100;
        for (int i = 0; i < 7; i++) begin
            pulse();
            chk($sformatf("ramp_up[%0d]", i), int'(d1), exp2[i]);
            if (i == 5) chk("at_before_end", int'(at1), 0);
        end
        chk("at_after_ramp", int'(at1), 1);
        repeat (3) pulse();
        chk("hold_100", int'(d1), 100);

        // Reverse to -40: brake, dwell, ramp negative
        target = -10'sd40;
        for (int i = 0; i < 7; i++) begin
            pulse();
            chk($sformatf("brake[%0d]", i), int'(d1), exp3[i]);
            chk($sformatf("brake_rev[%0d]", i), int'(rev1), 1);
        end
        for (int i = 0; i < 4; i++) begin
            pulse();
            chk($sformatf("dwell[%0d]", i), int'(d1), 0);
            chk($sformatf("dwell_rev[%0d]", i), int'(rev1), (i < 3) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk($sformatf("ramp_neg[%0d]", i), int'(d1), exp3b[i]);
        end

        // Most negative target saturates at -511
        target = -10'sd512;
        for (int i = 0; i < 35; i++) begin
            pulse();
            chk("never_min_neg", (int'(d1) == -512) ? 1 : 0, 0);
        end
        chk("sat_out", int'(d1), -511);
        chk("sat_at", int'(at1), 1);

        // Soft stop
        enable = 1'b0;
        repeat (40) pulse();
        chk("stop_out", int'(d1), 0);
        chk("stop_busy", int'(busy1), 0);
        chk("stop_rev", int'(rev1), 0);

        // Target and enable changing every cycle
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1 target = SIZE'($urandom);
            synch  = ((c % 6) < 3);
            enable = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk);
        #1 synch = 1'b0; enable = 1'b1; target = 10'sd100;

        // StepPeriods=3 instance
        @(negedge clk);
        #2 rst3 = 1'b1;
        #1 chk("dut3_async_reset", int'(d3), 0);
        #1 rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse();
            chk($sformatf("sp3[%0d]", i), int'(d3), exp5[i]);
        end
        pulse();
        @(negedge clk);
        #2 rst3 = 1'b1;
        #1 chk("midramp_reset_out", int'(d3), 0);
        chk("midramp_reset_at", int'(at3), 1);
        chk("midramp_reset_busy", int'(busy3), 0);
        #1 rst3 = 1'b0;
        repeat (2) pulse();
        chk("sp3_restart_hold", int'(d3), 0);
        pulse();
        chk("sp3_restart_first", int'(d3), 16);

`ifdef RAMP_ESTOP_EN
        // Emergency stop from +200
        target = 10'sd200;
        repeat (60) pulse();
        chk("estop_pre", int'(d1), 200);
        @(posedge clk); #1 estop = 1'b1;
        @(posedge clk); #1 estop = 1'b0;
        @(negedge clk);
        chk("estop_zero", int'(d1), 0);
        chk("estop_rev", int'(rev1), 1);
        for (int i = 0; i < 4; i++) begin
            pulse();
            chk($sformatf("estop_dwell[%0d]", i), int'(d1), 0);
        end
        pulse();
        chk("estop_ramp_first", int'(d1), 16);
`endif

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
